// File: rtl/hazard_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_unit_if : pipeline hazard controller signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             mem_branch_taken;
    logic             mem_access;
    logic             dmem_ready;

    logic             pc_enable;
    logic             if_id_enable;
    logic             if_id_flush;
    logic             id_ex_enable;
    logic             id_ex_flush;
    logic             ex_mem_enable;
    logic             ex_mem_flush;
    logic             mem_wb_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               mem_branch_taken, mem_access, dmem_ready,
        input  pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
               ex_mem_enable, ex_mem_flush, mem_wb_flush, mem_timeout,
               stall_cycles, flush_events
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               mem_branch_taken, mem_access, dmem_ready,
        output pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
               ex_mem_enable, ex_mem_flush, mem_wb_flush, mem_timeout,
               stall_cycles, flush_events
    );
endinterface

`default_nettype wire

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit : load-use / branch-flush / memory-wait pipeline controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  wire logic    clk,
    input  wire logic    reset,
    hazard_unit_if.slave hz
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] c_WAIT_MAX  = WC_W'(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] c_WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WC_W-1:0]   r_wait_cnt;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_mem_stall;
    logic w_br_flush;
    logic w_lu_raw;
    logic w_lu_stall;

    // Priority resolution: memory stall > branch flush > load-use
    always_comb begin
        w_mem_stall = hz.mem_access & ~hz.dmem_ready;
        w_lu_raw    = hz.ex_mem_read & (hz.ex_rt != 5'd0) &
                      ((hz.ex_rt == hz.id_rs) | (hz.id_uses_rt & (hz.ex_rt == hz.id_rt)));
        w_br_flush  = ~w_mem_stall & hz.mem_branch_taken;
        w_lu_stall  = ~w_mem_stall & ~hz.mem_branch_taken & w_lu_raw;
    end

    always_comb begin
        hz.pc_enable     = 1'b1;
        hz.if_id_enable  = 1'b1;
        hz.if_id_flush   = 1'b0;
        hz.id_ex_enable  = 1'b1;
        hz.id_ex_flush   = 1'b0;
        hz.ex_mem_enable = 1'b1;
        hz.ex_mem_flush  = 1'b0;
        hz.mem_wb_flush  = 1'b0;
        if (!reset) begin
            if (w_mem_stall) begin
                hz.pc_enable     = 1'b0;
                hz.if_id_enable  = 1'b0;
                hz.id_ex_enable  = 1'b0;
                hz.ex_mem_enable = 1'b0;
                hz.mem_wb_flush  = 1'b1;
            end else if (w_br_flush) begin
                hz.if_id_flush   = 1'b1;
                hz.id_ex_flush   = 1'b1;
                hz.ex_mem_flush  = 1'b1;
            end else if (w_lu_stall) begin
                hz.pc_enable     = 1'b0;
                hz.if_id_enable  = 1'b0;
                hz.id_ex_flush   = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:      if (w_mem_stall) w_state_nxt = ST_MEM_WAIT;
            ST_MEM_WAIT: if (hz.dmem_ready || !hz.mem_access) w_state_nxt = ST_RUN;
            default:     w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_mem_stall) begin
                if (r_wait_cnt != c_WAIT_MAX) r_wait_cnt <= r_wait_cnt + WC_W'(1);
                if (r_wait_cnt == c_WAIT_LAST) r_timeout <= 1'b1;
            end else if (r_state == ST_MEM_WAIT) begin
                r_wait_cnt <= '0;
            end
            if ((w_mem_stall || w_lu_stall) && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_br_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign hz.mem_timeout  = r_timeout;
    assign hz.stall_cycles = r_stall_cnt;
    assign hz.flush_events = r_flush_cnt;

endmodule

`default_nettype wire
